// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared types and constants for the shift-and-add multiplier controller.
package mult_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int unsigned DEF_N = 4;

  localparam logic SEL_HOLD = 1'b0;
  localparam logic SEL_SUM  = 1'b1;

endpackage

// File: rtl/shift_add_mult_ctrl_bit_cnt.sv
// Loadable down-counter tracking the remaining multiplier bits.
module mult_bit_cnt #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(N);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for a shift-and-add multiplier datapath.
// Optional early termination on an all-zero multiplier: SHIFT_ADD_EARLY_TERM_EN.
module shift_add_mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic mplr_zero,
  output logic busy,
  output logic done,
  output logic ld_op,
  output logic clr_acc,
  output logic sel_M,
  output logic acc_ld,
  output logic shift_en
);

  state_t state, state_nxt;
  logic   cnt_load, cnt_dec, cnt_last;

  mult_bit_cnt #(
    .N    (N),
    .CNT_W(CNT_W)
  ) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .dec (cnt_dec),
    .last(cnt_last)
  );

`ifndef SHIFT_ADD_EARLY_TERM_EN
  logic unused_mplr_zero;
  assign unused_mplr_zero = mplr_zero;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    ld_op     = 1'b0;
    clr_acc   = 1'b0;
    sel_M     = SEL_HOLD;
    acc_ld    = 1'b0;
    shift_en  = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        ld_op     = 1'b1;
        clr_acc   = 1'b1;
        cnt_load  = 1'b1;
        state_nxt = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
`ifdef SHIFT_ADD_EARLY_TERM_EN
        // Nothing left to add once the multiplier is empty: product is final.
        if (mplr_zero) begin
          state_nxt = DONE;
        end else begin
          sel_M     = q0 ? SEL_SUM : SEL_HOLD;
          acc_ld    = q0;
          state_nxt = SHIFT;
        end
`else
        sel_M     = q0 ? SEL_SUM : SEL_HOLD;
        acc_ld    = q0;
        state_nxt = SHIFT;
`endif
      end
      SHIFT: begin
        busy      = 1'b1;
        shift_en  = 1'b1;
        cnt_dec   = 1'b1;
        state_nxt = cnt_last ? DONE : EVAL;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl with a behavioural datapath model.
module tb_shift_add_mult_ctrl;

  logic clk = 1'b0;
  logic rst, start, q0, mplr_zero;
  logic busy, done, ld_op, clr_acc, sel_M, acc_ld, shift_en;

  logic [3:0] mcand_in, mplr_in;
  logic [7:0] mcand_r, acc_r;
  logic [3:0] mplr_r;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  typedef struct {
    logic [3:0] mcand;
    logic [3:0] mplr;
    logic [3:0] acc_mask;  // which EVAL iterations must add
    logic [7:0] prod;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.N(4), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .q0       (q0),
    .mplr_zero(mplr_zero),
    .busy     (busy),
    .done     (done),
    .ld_op    (ld_op),
    .clr_acc  (clr_acc),
    .sel_M    (sel_M),
    .acc_ld   (acc_ld),
    .shift_en (shift_en)
  );

  // Datapath model steered only by the controller's outputs
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r <= '0;
      mplr_r  <= '0;
      acc_r   <= '0;
    end else begin
      if (ld_op) begin
        mcand_r <= {4'b0000, mcand_in};
        mplr_r  <= mplr_in;
      end else if (shift_en) begin
        mcand_r <= mcand_r << 1;
        mplr_r  <= mplr_r >> 1;
      end
      if (clr_acc) acc_r <= '0;
      else if (acc_ld) acc_r <= sel_M ? acc_r + mcand_r : acc_r;
    end
  end

  assign q0        = mplr_r[0];
  assign mplr_zero = (mplr_r == 4'b0000);

  function automatic logic [6:0] outs();
    return {busy, done, ld_op, clr_acc, sel_M, acc_ld, shift_en};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Full N=4 sequence; outputs packed as {busy,done,ld_op,clr_acc,sel_M,acc_ld,shift_en}
  task automatic run_vec(input vec_t v, input string tag);
    logic [6:0] exp;
    chk({tag, " idle"}, {1'b0, outs()}, 8'h00);
    mcand_in = v.mcand;
    mplr_in  = v.mplr;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 1)           exp = 7'b1011000;
      else if (c == 10)     exp = 7'b0100000;
      else if (c % 2 == 1)  exp = 7'b1000001;
      else                  exp = v.acc_mask[(c-2)/2] ? 7'b1000110 : 7'b1000000;
      chk($sformatf("%s c%0d", tag, c), {1'b0, outs()}, {1'b0, exp});
      tick();
    end
    chk({tag, " product"}, acc_r, v.prod);
    chk({tag, " back idle"}, {1'b0, outs()}, 8'h00);
  endtask

  initial begin
    vecs[0] = '{4'b1101, 4'b1011, 4'b1011, 8'h8F};
    vecs[1] = '{4'b1111, 4'b1111, 4'b1111, 8'hE1};
    vecs[2] = '{4'b0101, 4'b0110, 4'b0110, 8'd30};
    vecs[3] = '{4'b1010, 4'b0001, 4'b0001, 8'd10};
    vecs[4] = '{4'b0011, 4'b1000, 4'b1000, 8'd24};

    start = 1'b0; mcand_in = '0; mplr_in = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset outs", {1'b0, outs()}, 8'h00);
    tick(); tick();
    chk("reset held outs", {1'b0, outs()}, 8'h00);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Zero multiplier
`ifdef SHIFT_ADD_EARLY_TERM_EN
    mcand_in = 4'b0110; mplr_in = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero c1", {1'b0, outs()}, 8'b01011000);
    tick();
    chk("zero c2", {1'b0, outs()}, 8'b01000000);
    tick();
    chk("zero c3 done", {1'b0, outs()}, 8'b00100000);
    tick();
    chk("zero product", acc_r, 8'h00);
    chk("zero idle", {1'b0, outs()}, 8'h00);
`else
    run_vec('{4'b0110, 4'b0000, 4'b0000, 8'h00}, "zero");
`endif

    // Reset asserted in the SHIFT of cycle 5
    mcand_in = 4'b1101; mplr_in = 4'b1011; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("pre-abort shift", {1'b0, outs()}, 8'b01000001);
    rst = 1'b1;
    #1;
    chk("abort outs", {1'b0, outs()}, 8'h00);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("post-abort idle %0d", c), {1'b0, outs()}, 8'h00);
      tick();
    end
    run_vec(vecs[0], "after abort");

    // start held high: done at 10, 21, 32; busy low only in DONE/IDLE
    mcand_in = 4'b1101; mplr_in = 4'b1011; start = 1'b1;
    tick();
    for (int c = 1; c <= 33; c++) begin
      if (c == 33) start = 1'b0;
      chk($sformatf("b2b c%0d", c), {6'b0, busy, done},
          {6'b0, !((c % 11 == 10) || (c % 11 == 0)), (c % 11 == 10)});
      tick();
    end
    chk("b2b settled", {1'b0, outs()}, 8'h00);

    // start pulsed in cycles 4 and 10 is ignored
    begin
      int unsigned n_done = 0;
      int unsigned done_cyc = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
        start = (c == 4) || (c == 10);
        if (done) begin
          n_done++;
          done_cyc = c;
        end
        if (c >= 11) chk($sformatf("pulse idle c%0d", c), {1'b0, outs()}, 8'h00);
        tick();
      end
      start = 1'b0;
      chk("pulse done count", 8'(n_done), 8'd1);
      chk("pulse done cycle", 8'(done_cyc), 8'd10);
      chk("pulse product", acc_r, 8'h8F);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
- Control FSM that sequences the shift-and-add multiplier datapath: operand load, accumulator clear, conditional add, shift, and completion.
- Drives the accumulator input mux select (sel_M: 0 = hold accumulator, 1 = adder sum), accumulator load, and shift enables. Samples the multiplier LSB from the datapath.
- Datapath convention:
  - multiplicand register shifts left;
  - multiplier register shifts right;
  - accumulator = accumulator + shifted multiplicand when the multiplier LSB is 1.

Parameters:
- N, 4, operand width in bits. Product is 2N = 8 bits.
- CNT_W, 3, bit-counter width. Must hold the value N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- q0  input  1  current multiplier-register LSB
- mplr_zero  input  1  multiplier register is all zeros; used only with the optional feature
- busy  output  1  high in LOAD, EVAL, SHIFT
- done  output  1  one-cycle pulse; product valid this cycle
- ld_op  output  1  load operand registers
- clr_acc  output  1  synchronously clear the accumulator
- sel_M  output  1  accumulator mux select
- acc_ld  output  1  accumulator register enable
- shift_en  output  1  shift multiplicand left and multiplier right

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state=IDLE, cnt=0. All outputs are 0 immediately on rst assertion, including mid-operation. No done pulse is issued for an aborted operation.
- States: IDLE, LOAD, EVAL, SHIFT, DONE. One-hot or binary encoding is acceptable.
- IDLE:
  - all outputs 0;
  - start=1 -> LOAD.
- LOAD:
  - ld_op=1, clr_acc=1, busy=1;
  - cnt <= N;
  - -> EVAL.
- EVAL:
  - busy=1; sel_M=q0, acc_ld=q0 (Mealy on q0);
  - -> SHIFT.
- SHIFT:
  - busy=1, shift_en=1; cnt <= cnt-1;
  - if cnt==1 -> DONE, else -> EVAL.
- DONE:
  - done=1, busy=0;
  - -> IDLE unconditionally. start is ignored in this state.
- Latency: start sampled at edge k -> LOAD in cycle k+1 -> N EVAL/SHIFT pairs -> done in cycle k+2N+2. For N=4, that is 10 cycles.
- Back-to-back: with start held high, the period is 2N+3 cycles (LOAD to LOAD).
- start in LOAD/EVAL/SHIFT/DONE: ignored. No queuing.
- q0 is sampled only in EVAL. Its value in other states has no effect.
- Outputs other than sel_M/acc_ld are Moore decodes of state.
- Counter never underflows: cnt==1 in SHIFT always exits to DONE.

Optional Feature:
- Macro: SHIFT_ADD_EARLY_TERM_EN
- Defined: in EVAL, if mplr_zero=1 then acc_ld=0, sel_M=0, and next state is DONE (SHIFT is skipped). Remaining iterations would add zero, so the product is already final. Minimum latency is LOAD -> EVAL -> DONE, i.e. done at cycle k+3.
- Undefined: mplr_zero is ignored (port kept, unused). Latency is always 2N+2.

Decomposition:
- Package mult_ctrl_pkg contains:
  - state enum (IDLE, LOAD, EVAL, SHIFT, DONE);
  - default N;
  - SEL_HOLD=1'b0 and SEL_SUM=1'b1 constants for sel_M.
- One sub-module, mult_bit_cnt: a loadable down-counter with load, dec, and last (cnt==1) outputs. The FSM stays in shift_add_mult_ctrl.

Test Plan:
- Reset mid-op: rst asserted during SHIFT in cycle 5 -> all outputs 0 in the same cycle, no done. After release, start -> normal 10-cycle sequence.
- Multiplier 1011, multiplicand 1101, start at edge 0 -> ld_op/clr_acc in cycle 1; acc_ld=sel_M=1 in cycles 2, 4, 8; shift_en in 3, 5, 7, 9; done in 10. Datapath model product = 143 (8'h8F).
- Multiplier 0000, macro undefined -> acc_ld never asserted, done in cycle 10, product 0. Macro defined -> done in cycle 3, no shift_en.
- start held high continuously -> done pulses in cycles 10, 21, 32. busy low only in DONE/IDLE cycles.
- start pulsed in cycles 4 and 10 during operation -> ignored; exactly one done, in cycle 10.
- Multiplier 1111 × 1111 -> acc_ld in all four EVAL cycles; product 225 (8'hE1); done in cycle 10.
